// File: rtl/lut_truth_table_reader.sv
// ---------------------------------------------------------------------------
// lut_truth_table_reader
//
// Purpose:
//   Readback engine for a generated LUT neuron. It walks every input code
//   0 .. 2^IN_BITS-1 through the neuron's combinational truth-table port and
//   samples the neuron output for each code. The samples are packed LSB-first
//   into WORD_W-bit words, and the words are streamed out over a valid/ready
//   interface. The resulting dump is compared against the trained model.
//
// Parameters:
//   IN_BITS   width of the neuron input code (table has 2^IN_BITS entries)
//   OUT_BITS  width of one table entry
//   WORD_W    width of one output word; must be a multiple of OUT_BITS, and
//             the total table size must be a multiple of WORD_W
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous, active-high reset
//   start     one-cycle sweep request, honoured only while idle
//   busy      high while a sweep is in progress (sampling or emitting)
//   done      one-cycle pulse after the final word has been accepted
//   lut_addr  registered input code driven into the neuron
//   lut_data  combinational neuron output for lut_addr
//   m_data    packed output word
//   m_valid   m_data is valid
//   m_ready   downstream accepts m_data
//   m_last    marks the final word of the dump (qualified by m_valid)
// ---------------------------------------------------------------------------
module lut_truth_table_reader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  // Entries per output word and number of words in the whole table.
  localparam int EPW    = WORD_W / OUT_BITS;
  localparam int NWORDS = ((1 << IN_BITS) * OUT_BITS) / WORD_W;

  // Counter widths; kept at least one bit wide for degenerate sizes.
  localparam int SLOT_W = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(EPW - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [IN_BITS-1:0]  lut_addr_r;
  logic [IN_BITS-1:0]  lut_addr_s;
  logic [SLOT_W-1:0]   slot_r;
  logic [SLOT_W-1:0]   slot_s;
  logic [WCNT_W-1:0]   word_r;
  logic [WCNT_W-1:0]   word_s;
  logic [WORD_W-1:0]   pack_r;
  logic [WORD_W-1:0]   pack_s;
  logic [WORD_W-1:0]   m_data_r;
  logic [WORD_W-1:0]   m_data_s;
  logic                m_last_r;
  logic                m_last_s;
  logic                m_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                done_s;

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lut_addr_r <= {IN_BITS{1'b0}};
      slot_r     <= {SLOT_W{1'b0}};
      word_r     <= {WCNT_W{1'b0}};
      pack_r     <= {WORD_W{1'b0}};
      m_data_r   <= {WORD_W{1'b0}};
      m_last_r   <= 1'b0;
      m_valid_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      lut_addr_r <= lut_addr_s;
      slot_r     <= slot_s;
      word_r     <= word_s;
      pack_r     <= pack_s;
      m_data_r   <= m_data_s;
      m_last_r   <= m_last_s;
      // Status flags are decoded from the next state so that they line up
      // with the state register rather than lagging it by a cycle.
      m_valid_r  <= (state_s == EMIT);
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  // Next-state and next-datapath logic for the sweep/emit sequencer.
  always_comb begin
    state_s    = state_r;
    lut_addr_s = lut_addr_r;
    slot_s     = slot_r;
    word_s     = word_r;
    pack_s     = pack_r;
    m_data_s   = m_data_r;
    m_last_s   = m_last_r;
    done_s     = 1'b0;

    case (state_r)
      IDLE: begin
        // Keep the sweep position parked at zero so a new sweep always
        // begins at code 0.
        lut_addr_s = {IN_BITS{1'b0}};
        slot_s     = {SLOT_W{1'b0}};
        word_s     = {WCNT_W{1'b0}};
        m_last_s   = 1'b0;
        if (start) begin
          state_s = SWEEP;
        end else begin
          state_s = IDLE;
        end
      end

      SWEEP: begin
        // The neuron output for the current code is captured into its slot.
        pack_s[int'(slot_r) * OUT_BITS +: OUT_BITS] = lut_data;
        // On the last slot this increment wraps the code to 0 at the end
        // of the table; that value is never sampled.
        lut_addr_s = lut_addr_r + IN_BITS'(1);
        if (slot_r == SLOT_LAST) begin
          // pack_s already holds the sample taken this cycle, so the word
          // handed downstream is complete.
          slot_s   = {SLOT_W{1'b0}};
          m_data_s = pack_s;
          m_last_s = (word_r == WORD_LAST);
          state_s  = EMIT;
        end else begin
          slot_s  = slot_r + SLOT_W'(1);
          state_s = SWEEP;
        end
      end

      EMIT: begin
        // m_valid is a registered decode of EMIT, so acceptance here only
        // depends on m_ready. lut_addr is left untouched: the sweep waits.
        if (m_ready) begin
          m_last_s = 1'b0;
          if (word_r == WORD_LAST) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            word_s  = word_r + WCNT_W'(1);
            state_s = SWEEP;
          end
        end else begin
          state_s = EMIT;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle state.
        state_s    = IDLE;
        lut_addr_s = {IN_BITS{1'b0}};
        slot_s     = {SLOT_W{1'b0}};
        word_s     = {WCNT_W{1'b0}};
        m_last_s   = 1'b0;
      end
    endcase
  end

  assign lut_addr = lut_addr_r;
  assign m_data   = m_data_r;
  assign m_valid  = m_valid_r;
  assign m_last   = m_last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
